seq_mult: RTL

//  Iterative shift-add multiplier: one multiplier bit per clock, WIDTH x WIDTH -> 2*WIDTH product.

---
 rtl/seq_mult_pkg.sv | 10 +
 rtl/seq_mult_abs.sv | 15 +
 rtl/seq_mult.sv | 116 +++++++++++
 3 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types for the iterative shift-add multiplier.
package seq_mult_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage : seq_mult_pkg

// File: rtl/seq_mult_abs.sv
// Operand conditioning: magnitude and sign of a WIDTH-bit value, signed or unsigned.
module seq_mult_abs #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic             signed_mode,
   output logic [WIDTH-1:0] mag_c,
   output logic             sign_c
);

   // |-2^(WIDTH-1)| wraps to 2^(WIDTH-1), which is exact as an unsigned magnitude
   assign sign_c = signed_mode & a[WIDTH-1];
   assign mag_c  = sign_c ? WIDTH'(~a + WIDTH'(1)) : a;

endmodule : seq_mult_abs

// File: rtl/seq_mult.sv
// Iterative shift-add multiplier: one multiplier bit per clock, WIDTH x WIDTH -> 2*WIDTH,
// unsigned or two's complement, with start/busy/done handshake.
module seq_mult
   import seq_mult_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   x,
   input  logic [WIDTH-1:0]   y,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] f
);

   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned CW = $clog2(WIDTH);

   state_t           state, state_next;
   logic [CW-1:0]    count;
   logic [PW-1:0]    mcand;
   logic [PW-1:0]    acc;
   logic [WIDTH-1:0] mplier;
   logic             neg;

   logic [WIDTH-1:0] xmag_c, ymag_c;
   logic             xsign_c, ysign_c;
   logic             accept_c, last_c;
   logic [PW-1:0]    sum_c;

   seq_mult_abs #(.WIDTH(WIDTH)) u_abs_x (
      .a           (x),
      .signed_mode (signed_mode),
      .mag_c       (xmag_c),
      .sign_c      (xsign_c)
   );

   seq_mult_abs #(.WIDTH(WIDTH)) u_abs_y (
      .a           (y),
      .signed_mode (signed_mode),
      .mag_c       (ymag_c),
      .sign_c      (ysign_c)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   // Next-state, accept/last strobes and the partial-product sum
   always_comb begin
      state_next = state;
      accept_c   = 1'b0;
      last_c     = 1'b0;
      sum_c      = acc + (mplier[0] ? mcand : PW'(0));
      case (state)
         S_IDLE: begin
            if (start) begin
               accept_c   = 1'b1;
               state_next = S_BUSY;
            end
         end
         S_BUSY: begin
            if (count == CW'(WIDTH - 1)) begin
               last_c     = 1'b1;
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            if (start) begin
               accept_c   = 1'b1;
               state_next = S_BUSY;
            end else begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Datapath and registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         count  <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         neg    <= 1'b0;
         f      <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         busy <= (state_next == S_BUSY);
         done <= (state_next == S_DONE);
         if (accept_c) begin
            mcand  <= {WIDTH'(0), xmag_c};
            mplier <= ymag_c;
            neg    <= xsign_c ^ ysign_c;
            acc    <= '0;
            count  <= '0;
         end else if (state == S_BUSY) begin
            acc    <= sum_c;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
            // magnitude product never exceeds 2^(PW-2), so negation cannot overflow
            if (last_c) f <= neg ? PW'(-sum_c) : sum_c;
         end
      end
   end

endmodule : seq_mult
